// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder-buffer controller.
//   Allocates up to MACHINE_WIDTH entries per cycle at the tail. Writeback
//   ports mark entries complete, optionally with an exception. Completed
//   entries retire in program order from the head, up to MACHINE_WIDTH per
//   cycle. An excepting entry at the head triggers a one-cycle FLUSH that
//   empties the buffer.
// Handshake: allocation transfers on a clock edge where alloc_ready is high
//   and at least one alloc_valid bit is set; alloc_ready never depends on
//   alloc_valid. retire_valid and flush are presented unconditionally, and
//   the consumer has no back-pressure.
// Ports:
//   clk, resetn                          clock, async active-low reset
//   alloc_valid/alloc_dst/alloc_pcplus8  per-slot allocate requests
//   alloc_ready, alloc_addr              room available, assigned addresses
//   wb_valid/wb_addr/wb_exc/wb_exccode   completion ports
//   retire_valid/addr/dst/pcplus8        in-order retirement slots
//   flush, flush_exccode, flush_epc      registered flush request
//   count                                occupied entries
//   o_dbg_state                          FSM state (1 = FLUSH)
module rob_ctrl #(
   parameter int ROB_DEPTH     = 16,
   parameter int MACHINE_WIDTH = 2,
   parameter int WB_PORTS      = 4,
   parameter int AW            = $clog2(ROB_DEPTH)
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [MACHINE_WIDTH-1:0]    alloc_valid,
   input  logic [MACHINE_WIDTH*5-1:0]  alloc_dst,
   input  logic [MACHINE_WIDTH*32-1:0] alloc_pcplus8,
   output logic                        alloc_ready,
   output logic [MACHINE_WIDTH*AW-1:0] alloc_addr,
   input  logic [WB_PORTS-1:0]         wb_valid,
   input  logic [WB_PORTS*AW-1:0]      wb_addr,
   input  logic [WB_PORTS-1:0]         wb_exc,
   input  logic [WB_PORTS*5-1:0]       wb_exccode,
   output logic [MACHINE_WIDTH-1:0]    retire_valid,
   output logic [MACHINE_WIDTH*AW-1:0] retire_addr,
   output logic [MACHINE_WIDTH*5-1:0]  retire_dst,
   output logic [MACHINE_WIDTH*32-1:0] retire_pcplus8,
   output logic                        flush,
   output logic [4:0]                  flush_exccode,
   output logic [31:0]                 flush_epc,
   output logic [AW:0]                 count,
   output logic                        o_dbg_state
);

   typedef enum logic {ST_NORMAL = 1'b0, ST_FLUSH = 1'b1} state_t;

   localparam logic [AW:0] DEPTH_C = (AW+1)'(ROB_DEPTH);
   localparam logic [AW:0] MW_C    = (AW+1)'(MACHINE_WIDTH);

   state_t              r_state;
   logic [AW-1:0]       r_head;
   logic [AW-1:0]       r_tail;
   logic [AW:0]         r_count;
   logic [ROB_DEPTH-1:0] r_valid;
   logic [ROB_DEPTH-1:0] r_complete;
   logic [ROB_DEPTH-1:0] r_exc;
   logic [4:0]          r_exccode [ROB_DEPTH];
   logic [4:0]          r_dst     [ROB_DEPTH];
   logic [31:0]         r_pcplus8 [ROB_DEPTH];
   logic                r_flush;
   logic [4:0]          r_flush_exccode;
   logic [31:0]         r_flush_epc;

   logic [AW:0]         w_free;
   logic                w_fire;
   logic [AW:0]         w_n_alloc;
   logic [AW:0]         w_alloc_cnt;
   logic [AW:0]         w_n_retire;
   logic                w_run;
   logic [AW-1:0]       w_ridx [MACHINE_WIDTH];
   logic                w_head_exc;

   // Occupancy alone decides room; retirements in this cycle do not help.
   assign w_free      = DEPTH_C - r_count;
   assign alloc_ready = (r_state == ST_NORMAL) && (w_free >= MW_C);
   assign w_fire      = alloc_ready && (|alloc_valid);
   assign w_alloc_cnt = w_fire ? w_n_alloc : '0;

   // Valid slots are packed: each slot takes tail plus the number of valid
   // slots below it. Invalid slots still show their would-be address.
   always_comb begin
      alloc_addr = '0;
      w_n_alloc  = '0;
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
         alloc_addr[i*AW +: AW] = r_tail + w_n_alloc[AW-1:0];
         w_n_alloc = w_n_alloc + (AW+1)'(alloc_valid[i]);
      end
   end

   // Retire is a prefix of clean, completed entries starting at head; the
   // first incomplete or excepting entry stops the group.
   always_comb begin
      retire_valid   = '0;
      retire_addr    = '0;
      retire_dst     = '0;
      retire_pcplus8 = '0;
      w_n_retire     = '0;
      w_run          = (r_state == ST_NORMAL);
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
         w_ridx[i] = r_head + AW'(i);
         retire_addr[i*AW +: AW]   = w_ridx[i];
         retire_dst[i*5 +: 5]      = r_dst[w_ridx[i]];
         retire_pcplus8[i*32 +: 32] = r_pcplus8[w_ridx[i]];
         w_run = w_run & r_valid[w_ridx[i]] & r_complete[w_ridx[i]] & ~r_exc[w_ridx[i]];
         retire_valid[i] = w_run;
         w_n_retire = w_n_retire + (AW+1)'(w_run);
      end
   end

   assign w_head_exc = (r_state == ST_NORMAL) && r_valid[r_head] &&
                       r_complete[r_head] && r_exc[r_head];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state         <= ST_NORMAL;
         r_head          <= '0;
         r_tail          <= '0;
         r_count         <= '0;
         r_valid         <= '0;
         r_complete      <= '0;
         r_exc           <= '0;
         r_flush         <= 1'b0;
         r_flush_exccode <= '0;
         r_flush_epc     <= '0;
         for (int e = 0; e < ROB_DEPTH; e++) begin
            r_exccode[e] <= '0;
            r_dst[e]     <= '0;
            r_pcplus8[e] <= '0;
         end
      end else begin
         case (r_state)
            ST_NORMAL: begin
               // Highest port first so the lowest excepting port writes last.
               for (int p = WB_PORTS-1; p >= 0; p--) begin
                  if (wb_valid[p] && r_valid[wb_addr[p*AW +: AW]]) begin
                     r_complete[wb_addr[p*AW +: AW]] <= 1'b1;
                     if (wb_exc[p]) begin
                        r_exc[wb_addr[p*AW +: AW]]     <= 1'b1;
                        r_exccode[wb_addr[p*AW +: AW]] <= wb_exccode[p*5 +: 5];
                     end
                  end
               end
               if (w_fire) begin
                  for (int i = 0; i < MACHINE_WIDTH; i++) begin
                     if (alloc_valid[i]) begin
                        r_valid[alloc_addr[i*AW +: AW]]    <= 1'b1;
                        r_complete[alloc_addr[i*AW +: AW]] <= 1'b0;
                        r_exc[alloc_addr[i*AW +: AW]]      <= 1'b0;
                        r_dst[alloc_addr[i*AW +: AW]]      <= alloc_dst[i*5 +: 5];
                        r_pcplus8[alloc_addr[i*AW +: AW]]  <= alloc_pcplus8[i*32 +: 32];
                     end
                  end
               end
               // Retiring entries are cleared last so nothing re-marks them.
               for (int i = 0; i < MACHINE_WIDTH; i++) begin
                  if (retire_valid[i]) begin
                     r_valid[w_ridx[i]]    <= 1'b0;
                     r_complete[w_ridx[i]] <= 1'b0;
                     r_exc[w_ridx[i]]      <= 1'b0;
                  end
               end
               r_tail  <= r_tail + w_alloc_cnt[AW-1:0];
               r_head  <= r_head + w_n_retire[AW-1:0];
               r_count <= r_count + w_alloc_cnt - w_n_retire;
               if (w_head_exc) begin
                  r_state         <= ST_FLUSH;
                  r_flush         <= 1'b1;
                  r_flush_exccode <= r_exccode[r_head];
                  r_flush_epc     <= r_pcplus8[r_head] - 32'd8;
               end
            end
            ST_FLUSH: begin
               r_valid    <= '0;
               r_complete <= '0;
               r_exc      <= '0;
               r_head     <= '0;
               r_tail     <= '0;
               r_count    <= '0;
               r_flush    <= 1'b0;
               r_state    <= ST_NORMAL;
            end
         endcase
      end
   end

   assign flush         = r_flush;
   assign flush_exccode = r_flush_exccode;
   assign flush_epc     = r_flush_epc;
   assign count         = r_count;
   assign o_dbg_state   = (r_state == ST_FLUSH);

endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: directed bench for rob_ctrl. Stimulus pushes expected
// retirements and flushes into queues; a monitor on the falling edge pops
// them whenever the DUT presents retire_valid or flush.
module tb_rob_ctrl;
   localparam int D  = 16;
   localparam int MW = 2;
   localparam int WP = 4;
   localparam int AW = 4;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic [MW-1:0]     alloc_valid;
   logic [MW*5-1:0]   alloc_dst;
   logic [MW*32-1:0]  alloc_pcplus8;
   logic              alloc_ready;
   logic [MW*AW-1:0]  alloc_addr;
   logic [WP-1:0]     wb_valid;
   logic [WP*AW-1:0]  wb_addr;
   logic [WP-1:0]     wb_exc;
   logic [WP*5-1:0]   wb_exccode;
   logic [MW-1:0]     retire_valid;
   logic [MW*AW-1:0]  retire_addr;
   logic [MW*5-1:0]   retire_dst;
   logic [MW*32-1:0]  retire_pcplus8;
   logic              flush;
   logic [4:0]        flush_exccode;
   logic [31:0]       flush_epc;
   logic [AW:0]       count;
   logic              dbg_state;

   int total = 0;
   int bad   = 0;
   logic [40:0] exp_q[$];    // {addr, dst, pcplus8}
   logic [36:0] flush_q[$];  // {exccode, epc}

   rob_ctrl #(.ROB_DEPTH(D), .MACHINE_WIDTH(MW), .WB_PORTS(WP), .AW(AW)) dut (
      .clk(clk), .resetn(resetn),
      .alloc_valid(alloc_valid), .alloc_dst(alloc_dst), .alloc_pcplus8(alloc_pcplus8),
      .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_exc(wb_exc), .wb_exccode(wb_exccode),
      .retire_valid(retire_valid), .retire_addr(retire_addr), .retire_dst(retire_dst),
      .retire_pcplus8(retire_pcplus8),
      .flush(flush), .flush_exccode(flush_exccode), .flush_epc(flush_epc),
      .count(count), .o_dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [40:0] act, input logic [40:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      alloc_valid   = '0;
      alloc_dst     = '0;
      alloc_pcplus8 = '0;
      wb_valid      = '0;
      wb_addr       = '0;
      wb_exc        = '0;
      wb_exccode    = '0;
   endtask

   task automatic do_alloc(input logic [1:0] v, input logic [4:0] d0, input logic [4:0] d1,
                           input logic [31:0] p0, input logic [31:0] p1, input bit push,
                           input logic [3:0] a0, input logic [3:0] a1);
      alloc_valid   = v;
      alloc_dst     = {d1, d0};
      alloc_pcplus8 = {p1, p0};
      #1;
      chk("alloc_ready", {40'd0, alloc_ready}, 41'd1);
      chk("alloc_addr0", {37'd0, alloc_addr[3:0]}, {37'd0, a0});
      chk("alloc_addr1", {37'd0, alloc_addr[7:4]}, {37'd0, a1});
      if (push) begin
         if (v[0]) exp_q.push_back({a0, d0, p0});
         if (v[1]) exp_q.push_back({a1, d1, p1});
      end
      step();
      alloc_valid = '0;
   endtask

   task automatic do_wb(input logic [3:0] v, input logic [15:0] a, input logic [3:0] e,
                        input logic [19:0] c);
      wb_valid   = v;
      wb_addr    = a;
      wb_exc     = e;
      wb_exccode = c;
      step();
      wb_valid = '0;
      wb_exc   = '0;
   endtask

   task automatic pulse_reset();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      step();
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (resetn) begin
         for (int i = 0; i < MW; i++) begin
            if (retire_valid[i]) begin
               if (exp_q.size() == 0) begin
                  chk("retire_unexpected", {retire_addr[i*AW +: AW], retire_dst[i*5 +: 5],
                      retire_pcplus8[i*32 +: 32]}, 41'd0);
               end else begin
                  chk("retire_entry", {retire_addr[i*AW +: AW], retire_dst[i*5 +: 5],
                      retire_pcplus8[i*32 +: 32]}, exp_q.pop_front());
               end
            end
         end
         if (flush) begin
            if (flush_q.size() == 0) begin
               chk("flush_unexpected", {4'd0, flush_exccode, flush_epc}, 41'd0);
            end else begin
               chk("flush_entry", {4'd0, flush_exccode, flush_epc}, {4'd0, flush_q.pop_front()});
            end
         end
      end
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      clear_inputs();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_count", {36'd0, count}, 41'd0);
      chk("rst_ready", {40'd0, alloc_ready}, 41'd1);
      chk("rst_retire", {39'd0, retire_valid}, 41'd0);
      chk("rst_flush", {40'd0, flush}, 41'd0);
      chk("rst_epc", {9'd0, flush_epc}, 41'd0);
      step();

      // basic allocate, out-of-order completion, 2-wide retire
      do_alloc(2'b11, 5'd2, 5'd3, 32'hBFC00008, 32'hBFC0000C, 1'b1, 4'd0, 4'd1);
      chk("t2_count", {36'd0, count}, 41'd2);
      do_wb(4'b0001, 16'h0001, 4'b0000, 20'h0);
      chk("t2_no_retire", {39'd0, retire_valid}, 41'd0);
      do_wb(4'b0001, 16'h0000, 4'b0000, 20'h0);
      chk("t2_retire_both", {39'd0, retire_valid}, 41'd3);
      step();
      chk("t2_count_empty", {36'd0, count}, 41'd0);

      // compaction of sparse slots
      do_alloc(2'b11, 5'd4, 5'd5, 32'h1000, 32'h1004, 1'b1, 4'd2, 4'd3);
      do_alloc(2'b01, 5'd6, 5'd7, 32'h1008, 32'h0, 1'b1, 4'd4, 4'd5);
      do_alloc(2'b10, 5'd0, 5'd8, 32'h0, 32'h100C, 1'b1, 4'd5, 4'd5);
      chk("t3_count", {36'd0, count}, 41'd4);
      do_wb(4'b1111, {4'd5, 4'd4, 4'd3, 4'd2}, 4'b0000, 20'h0);
      chk("t3_retire_a", {39'd0, retire_valid}, 41'd3);
      step();
      chk("t3_retire_b", {39'd0, retire_valid}, 41'd3);
      step();
      chk("t3_count_empty", {36'd0, count}, 41'd0);

      // fill to full, then wrap
      pulse_reset();
      for (int k = 0; k < 8; k++) begin
         do_alloc(2'b11, 5'(2*k), 5'(2*k+1), 32'h2000_0000 + 32'(k*16),
                  32'h2000_0004 + 32'(k*16), 1'b1, 4'(2*k), 4'(2*k+1));
      end
      chk("t4_full_count", {36'd0, count}, 41'd16);
      chk("t4_full_ready", {40'd0, alloc_ready}, 41'd0);
      alloc_valid = 2'b11;
      step();
      alloc_valid = '0;
      chk("t4_full_hold", {36'd0, count}, 41'd16);
      do_wb(4'b0011, {8'd0, 4'd1, 4'd0}, 4'b0000, 20'h0);
      chk("t4_retire_full", {39'd0, retire_valid}, 41'd3);
      chk("t4_no_bypass", {40'd0, alloc_ready}, 41'd0);
      step();
      chk("t4_count14", {36'd0, count}, 41'd14);
      do_alloc(2'b11, 5'd20, 5'd21, 32'h2100_0000, 32'h2100_0004, 1'b1, 4'd0, 4'd1);
      chk("t4_refull", {36'd0, count}, 41'd16);
      do_wb(4'b1111, {4'd5, 4'd4, 4'd3, 4'd2}, 4'b0000, 20'h0);
      do_wb(4'b1111, {4'd9, 4'd8, 4'd7, 4'd6}, 4'b0000, 20'h0);
      do_wb(4'b1111, {4'd13, 4'd12, 4'd11, 4'd10}, 4'b0000, 20'h0);
      do_wb(4'b1111, {4'd1, 4'd0, 4'd15, 4'd14}, 4'b0000, 20'h0);
      repeat (8) step();
      chk("t4_drained", {36'd0, count}, 41'd0);

      // exception at head -> one-cycle flush
      pulse_reset();
      do_alloc(2'b11, 5'd1, 5'd2, 32'hBFC00108, 32'hBFC0010C, 1'b0, 4'd0, 4'd1);
      do_alloc(2'b11, 5'd3, 5'd4, 32'hBFC00110, 32'hBFC00114, 1'b0, 4'd2, 4'd3);
      do_wb(4'b0001, 16'h0000, 4'b0001, 20'h0000C);
      chk("t5_exc_no_retire", {39'd0, retire_valid}, 41'd0);
      chk("t5_pre_flush", {40'd0, flush}, 41'd0);
      flush_q.push_back({5'h0C, 32'hBFC00100});
      step();
      chk("t5_flush", {40'd0, flush}, 41'd1);
      chk("t5_exccode", {36'd0, flush_exccode}, 41'h0C);
      chk("t5_epc", {9'd0, flush_epc}, {9'd0, 32'hBFC00100});
      chk("t5_flush_ready", {40'd0, alloc_ready}, 41'd0);
      chk("t5_flush_retire", {39'd0, retire_valid}, 41'd0);
      chk("t5_flush_state", {40'd0, dbg_state}, 41'd1);
      alloc_valid = 2'b11;
      step();
      alloc_valid = '0;
      chk("t5_post_flush", {40'd0, flush}, 41'd0);
      chk("t5_post_count", {36'd0, count}, 41'd0);
      chk("t5_post_ready", {40'd0, alloc_ready}, 41'd1);
      chk("t5_post_state", {40'd0, dbg_state}, 41'd0);

      // same-address writeback priority, writeback to an unallocated entry
      do_alloc(2'b11, 5'd10, 5'd11, 32'h3008, 32'h300C, 1'b1, 4'd0, 4'd1);
      do_alloc(2'b11, 5'd12, 5'd13, 32'h3010, 32'h3014, 1'b0, 4'd2, 4'd3);
      do_wb(4'b0001, 16'h0004, 4'b0001, 20'h0001F);
      chk("t6_inval_count", {36'd0, count}, 41'd4);
      chk("t6_inval_retire", {39'd0, retire_valid}, 41'd0);
      do_wb(4'b1111, {4'd2, 4'd1, 4'd2, 4'd0}, 4'b1010, {5'h05, 5'h00, 5'h04, 5'h00});
      chk("t6_retire_older", {39'd0, retire_valid}, 41'd3);
      flush_q.push_back({5'h04, 32'h3008});
      step();
      chk("t6_blocked", {39'd0, retire_valid}, 41'd0);
      chk("t6_count2", {36'd0, count}, 41'd2);
      step();
      chk("t6_flush", {40'd0, flush}, 41'd1);
      chk("t6_exccode", {36'd0, flush_exccode}, 41'h04);
      step();
      chk("t6_count_empty", {36'd0, count}, 41'd0);

      step();
      chk("retire_q_empty", 41'(exp_q.size()), 41'd0);
      chk("flush_q_empty", 41'(flush_q.size()), 41'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
